// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divisor helper.
// Used by uart_rx and intended for reuse by the matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } uart_state_t;

  function automatic int clks_per_bit(input int clock_hz, input int baud_rate);
    return clock_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 so an
// idle-high serial line reads as idle straight out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] ff_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) ff_reg[gi] <= 1'b1;
          else     ff_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) ff_reg[gi] <= 1'b1;
          else     ff_reg[gi] <= ff_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = ff_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a one-entry valid/ready holding register
// and framing/overrun pulses. Define UART_RX_PARITY_EN for 8E1 with parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  logic rx_s;

  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shreg_reg, shreg_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             done_reg, done_next;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg, overrun_next;
`ifdef UART_RX_PARITY_EN
  logic             par_reg, par_next;
  logic             parity_err_reg, parity_err_next;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shreg_next     = shreg_reg;
    done_next      = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next        = par_reg;
    parity_err_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit so short glitches are ignored.
        if (cnt_reg == CNT_HALF) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_s, shreg_reg[7:1]};
          if (idx_reg == 3'd7) state_next = AFTER_DATA;
          else                 idx_next   = idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          par_next   = rx_s;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_next = ^{shreg_reg, par_reg};
`endif
          if (rx_s) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = RECOVER;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RECOVER: begin
        // A held-low line (break) must go high before a new start bit counts.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = 1'b0;
    if (done_reg) begin
      if (!valid_reg || rx_ready) begin
        data_next  = shreg_reg;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && rx_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shreg_reg     <= '0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shreg_reg     <= shreg_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      done_reg      <= done_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_reg        <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      par_reg        <= par_next;
      parity_err_reg <= parity_err_next;
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = data_reg;
  assign rx_valid    = valid_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_reg;

endmodule
